// File: rtl/matrix_keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, samples the
// synchronized rows, debounces whole frames and reports press/release events.
module matrix_keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [3:0]  col_n,
    input  logic [3:0]  row_n,
    output logic [15:0] key_map,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic        key_press,
    output logic        key_release
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MW = $clog2(DEBOUNCE_FRAMES + 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_t;

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [SW-1:0] r_slot;
    logic [1:0]    r_col;
    logic [15:0]   r_raw;
    logic [15:0]   r_prev;
    logic [MW-1:0] r_match;
    logic          r_load;
    state_t        r_state;

    logic          w_slot_wrap;
    logic          w_frame_done;
    logic [1:0]    w_col_next;
    logic [15:0]   w_frame;
    logic [MW-1:0] w_match_next;
    logic [15:0]   w_map_next;
    state_t        w_state_next;
    logic          w_press_next;
    logic          w_release_next;
    logic [3:0]    w_code_next;

    function automatic logic [3:0] lowest_bit(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign w_slot_wrap  = (r_slot == SW'(SCAN_DIV - 1));
    assign w_frame_done = w_slot_wrap && (r_col == 2'd3);
    assign w_col_next   = r_col + 2'd1;
    assign w_map_next   = r_load ? r_prev : key_map;

    // Two-flop synchronizer for the asynchronous row inputs (idle = all high)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= row_n;
            r_sync2 <= r_sync1;
        end
    end

    // Slot counter and column drive
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot <= '0;
            r_col  <= 2'd0;
            col_n  <= 4'b1110;
        end else if (w_slot_wrap) begin
            r_slot <= '0;
            r_col  <= w_col_next;
            col_n  <= ~(4'b0001 << w_col_next);
        end else begin
            r_slot <= r_slot + SW'(1);
        end
    end

    // Raw frame with the current column's nibble replaced by the live sample
    always_comb begin
        w_frame = r_raw;
        w_frame[{r_col, 2'b00} +: 4] = ~r_sync2;
    end

    // Frame-to-frame match counter, saturating at DEBOUNCE_FRAMES
    always_comb begin
        w_match_next = MW'(1);
        if (w_frame == r_prev) begin
            if (r_match == MW'(DEBOUNCE_FRAMES)) begin
                w_match_next = r_match;
            end else begin
                w_match_next = r_match + MW'(1);
            end
        end else begin
            w_match_next = MW'(1);
        end
    end

    // Frame capture and debounce bookkeeping; r_load flags a stable frame in r_prev
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_raw   <= 16'h0000;
            r_prev  <= 16'h0000;
            r_match <= MW'(DEBOUNCE_FRAMES);
            r_load  <= 1'b0;
        end else begin
            if (w_slot_wrap) begin
                r_raw <= w_frame;
            end
            if (w_frame_done) begin
                r_prev  <= w_frame;
                r_match <= w_match_next;
                r_load  <= (w_match_next == MW'(DEBOUNCE_FRAMES));
            end else begin
                r_load  <= 1'b0;
            end
        end
    end

    // Output FSM next-state and event decode, evaluated against the upcoming key_map
    always_comb begin
        w_state_next   = r_state;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        w_code_next    = key_code;
        case (r_state)
            ST_IDLE: begin
                if (w_map_next != 16'h0000) begin
                    w_state_next = ST_PRESSED;
                    w_press_next = 1'b1;
                    w_code_next  = lowest_bit(w_map_next);
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (w_map_next == 16'h0000) begin
                    w_state_next   = ST_IDLE;
                    w_release_next = 1'b1;
                end else begin
                    w_state_next = ST_PRESSED;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Registered state and outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            key_map     <= 16'h0000;
            key_code    <= 4'd0;
            key_down    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            key_map     <= w_map_next;
            key_code    <= w_code_next;
            key_down    <= (w_state_next == ST_PRESSED);
            key_press   <= w_press_next;
            key_release <= w_release_next;
        end
    end

endmodule
